// File: rtl/bist_engine_param.sv
// Parameterised logic-BIST engine: an LFSR pattern generator, a MISR response
// compactor and a five-state run controller, with a 16-bit status/display bus.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   mode       00 idle/hold, 01 free-run LFSR, 10 BIST run, 11 signature display
//   start      one-cycle BIST request, honoured in mode 10 only
//   resp       circuit-under-test response to the current pattern
//   pattern    current LFSR state
//   signature  current MISR state
//   busy       high in INIT, RUN and COMPARE
//   done       high in DONE
//   pass       high in DONE when the signature matches GOLDEN
//   led        display bus, one cycle behind its source
module bist_engine_param #(
  parameter int unsigned WIDTH    = 16,
  parameter logic [31:0] POLY     = 32'h0000_B400,
  parameter logic [31:0] SEED     = 32'h0000_ACE1,
  parameter int unsigned PATTERNS = 1024,
  parameter logic [31:0] GOLDEN   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      led
);

  localparam int unsigned CNT_W = $clog2(PATTERNS + 1);

  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] GOLD_W = GOLDEN[WIDTH-1:0];
  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [WIDTH-1:0] LOAD_VAL = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PATTERNS);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_BIST = 2'b10;
  localparam logic [1:0] MODE_DISP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CMP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      led_q, led_d;

  logic             bist_mode_c;
  logic             running_c;

  // One Galois right-shift step; shared by the LFSR and the MISR.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
    return v[0] ? ((v >> 1) ^ POLY_W) : (v >> 1);
  endfunction

  assign bist_mode_c = (mode == MODE_BIST);
  assign running_c   = (state_q == S_RUN);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LOAD_VAL;
      misr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      led_q   <= led_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pass_d  = 1'b0;
    led_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (mode == MODE_FREE) lfsr_d = galois_step(lfsr_q);
        if (bist_mode_c && start) state_d = S_INIT;
      end
      S_INIT: begin
        // Leaving mode 10 aborts before anything is reloaded.
        if (!bist_mode_c) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d  = LOAD_VAL;
          misr_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!bist_mode_c) begin
          state_d = S_IDLE;
        end else begin
          misr_d = galois_step(misr_q) ^ resp;
          lfsr_d = galois_step(lfsr_q);
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // This cycle absorbs the last pattern.
          if (cnt_q == CNT_LAST) state_d = S_CMP;
        end
      end
      S_CMP: begin
        state_d = bist_mode_c ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (mode == MODE_DISP) begin
          state_d = S_DONE;
        end else if (bist_mode_c) begin
          if (start) state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_CMP);
    done_d = (state_d == S_DONE);
    // pass is latched on COMPARE -> DONE, kept through DONE, cleared otherwise.
    if (state_d == S_DONE) begin
      pass_d = (state_q == S_CMP) ? (misr_q == GOLD_W) : pass_q;
    end

    unique case (mode)
      MODE_HOLD: led_d = 16'h0000;
      MODE_FREE: led_d = 16'(lfsr_q);
      MODE_BIST: led_d = {12'h000, pass_q, done_q, busy_q, running_c};
      MODE_DISP: led_d = 16'(misr_q);
      default:   led_d = 16'h0000;
    endcase
  end

  assign pattern   = lfsr_q;
  assign signature = misr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign led       = led_q;

endmodule

// File: tb/tb_bist_engine_param.sv
// Directed bench for bist_engine_param: a 4-pattern instance covers free-run,
// BIST runs, abort and reset-in-COMPARE; a zero-seed instance covers lock-up.
module tb_bist_engine_param;

  localparam int unsigned W    = 16;
  localparam int unsigned NP   = 4;
  localparam logic [15:0] SEED_M = 16'hACE1;
  localparam logic [15:0] POLY_M = 16'hB400;
  localparam logic [15:0] GOLD_M = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   mode;
  logic         start;
  logic [W-1:0] resp;
  logic [W-1:0] pattern, signature;
  logic         busy, done, pass;
  logic [15:0]  led;

  logic [1:0]   s0_mode;
  logic [W-1:0] s0_pattern, s0_signature;
  logic         s0_busy, s0_done, s0_pass;
  logic [15:0]  s0_led;

  bist_engine_param #(
    .WIDTH(W), .POLY(32'(POLY_M)), .SEED(32'(SEED_M)), .PATTERNS(NP), .GOLDEN(32'(GOLD_M))
  ) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .resp(resp),
    .pattern(pattern), .signature(signature), .busy(busy), .done(done),
    .pass(pass), .led(led)
  );

  bist_engine_param #(
    .WIDTH(W), .SEED(32'h0)
  ) u_s0 (
    .clk(clk), .rst(rst), .mode(s0_mode), .start(1'b0), .resp('0),
    .pattern(s0_pattern), .signature(s0_signature), .busy(s0_busy), .done(s0_done),
    .pass(s0_pass), .led(s0_led)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference model of the Galois step.
  function automatic logic [15:0] m_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ POLY_M) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Full BIST run from IDLE or DONE. rmode: 0 resp=0, 1 resp=pattern,
  // 2 resp=pattern with bit 0 flipped on pattern 3.
  task automatic run_bist(input string name, input int rmode);
    logic [15:0] p, m;
    logic [15:0] rs[1:NP];
    int lat, busy_cnt;
    p = SEED_M;
    m = '0;
    for (int k = 1; k <= NP; k++) begin
      rs[k] = (rmode == 0) ? 16'h0000 : p;
      if (rmode == 2 && k == 3) rs[k] = rs[k] ^ 16'h0001;
      m = m_step(m) ^ rs[k];
      p = m_step(p);
    end
    sb_push({name, "_latency"}, 32'(NP + 2));
    sb_push({name, "_busy_cycles"}, 32'(NP + 2));
    sb_push({name, "_signature"}, 32'(m));
    sb_push({name, "_pass"}, 32'(m == GOLD_M));

    mode  = 2'b10;
    start = 1'b1;
    resp  = '0;
    tick();
    start = 1'b0;
    check({name, "_init_done"}, 32'(done), 32'd0);
    check({name, "_init_pass"}, 32'(pass), 32'd0);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      resp = (n >= 2 && n <= NP + 1) ? rs[n-1] : '0;
      tick();
      if (busy) busy_cnt++;
      if (done) lat = n;
    end
    resp = '0;
    sb_pop(32'(lat));
    sb_pop(32'(busy_cnt));
    sb_pop(32'(signature));
    sb_pop(32'(pass));
  endtask

  initial begin
    logic [15:0] p;
    logic        zero_seen;

    // Reset.
    rst     = 1'b0;
    mode    = 2'b00;
    s0_mode = 2'b00;
    start   = 1'b0;
    resp    = '0;
    tick();
    tick();
    check("rst_pattern", 32'(pattern), 32'(SEED_M));
    check("rst_signature", 32'(signature), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("s0_rst_pattern", 32'(s0_pattern), 32'h0001);

    // Free-run: pattern steps per edge, led lags by one.
    rst  = 1'b1;
    mode = 2'b01;
    p    = SEED_M;
    for (int i = 0; i < 3; i++) begin
      sb_push("free_pattern", 32'(m_step(p)));
      sb_push("free_led", 32'(p));
      tick();
      sb_pop(32'(pattern));
      sb_pop(32'(led));
      p = m_step(p);
    end

    // Mode 00 holds the LFSR and blanks the display.
    mode = 2'b00;
    tick();
    tick();
    check("hold_pattern", 32'(pattern), 32'(p));
    check("hold_led", 32'(led), 32'd0);

    // Matching run, then status on led in DONE.
    run_bist("run_match", 1);
    tick();
    check("done_led_status", 32'(led), 32'h000C);

    // Re-run from DONE with a corrupted response.
    run_bist("run_flip", 2);

    // Signature display keeps DONE.
    mode = 2'b11;
    tick();
    check("disp_done", 32'(done), 32'd1);
    check("disp_led", 32'(led), 32'hB400);

    // Leaving DONE through mode 00.
    mode = 2'b00;
    tick();
    check("exit_done", 32'(done), 32'd0);
    check("exit_pass", 32'(pass), 32'd0);
    check("exit_busy", 32'(busy), 32'd0);
    check("exit_led", 32'(led), 32'd0);

    // Zero-response run.
    run_bist("run_zero", 0);

    // Abort during RUN cycle 2.
    mode  = 2'b00;
    tick();
    mode  = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    resp  = 16'h5A5A;
    tick();
    tick();
    mode = 2'b01;
    resp = '0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_signature", 32'(signature), 32'(m_step(16'h0000) ^ 16'h5A5A));
    check("abort_pattern", 32'(pattern), 32'(m_step(SEED_M)));
    tick();
    check("abort_resume", 32'(pattern), 32'(m_step(m_step(SEED_M))));

    // Reset while in COMPARE.
    mode  = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    resp  = 16'h1234;
    for (int i = 0; i < NP + 1; i++) tick();
    check("cmp_busy", 32'(busy), 32'd1);
    rst  = 1'b0;
    resp = '0;
    tick();
    check("cmprst_pattern", 32'(pattern), 32'(SEED_M));
    check("cmprst_signature", 32'(signature), 32'd0);
    check("cmprst_busy", 32'(busy), 32'd0);
    check("cmprst_done", 32'(done), 32'd0);
    check("cmprst_pass", 32'(pass), 32'd0);
    check("cmprst_led", 32'(led), 32'd0);
    rst = 1'b1;
    run_bist("run_after_rst", 0);

    // Zero seed never reaches the lock-up state.
    s0_mode   = 2'b01;
    zero_seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (s0_pattern == '0) zero_seen = 1'b1;
    end
    check("s0_no_lockup", 32'(zero_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
